pong_sound_arbiter: RTL and testbench



---
 rtl/pong_sound_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_pong_sound_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pong_sound_arbiter.sv
// pong_sound_arbiter: arbitrates wall/paddle/score sound requests into a single
// square-wave tone generator. Priority is score > paddle > wall. A tone plays
// for a fixed number of video frames, then the block returns to idle.
// Optional feature macro: SOUND_ARB_QUEUE_EN. When it is defined, lower-priority
// requests made during a tone are remembered and played once that tone ends.
// When it is undefined, such requests are dropped and no pending storage exists.
module pong_sound_arbiter #(
  parameter logic [15:0] HALF_WALL   = 16'd25175,
  parameter logic [15:0] HALF_PADDLE = 16'd12587,
  parameter logic [15:0] HALF_SCORE  = 16'd50350,
  parameter logic [5:0]  DUR_WALL    = 6'd4,
  parameter logic [5:0]  DUR_PADDLE  = 6'd4,
  parameter logic [5:0]  DUR_SCORE   = 6'd30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       frame_tick,
  input  logic       req_wall,
  input  logic       req_paddle,
  input  logic       req_score,
  output logic       sound_out,
  output logic       busy,
  output logic [1:0] active_id
);

  typedef enum logic {IDLE, PLAY} state_t;

  // Source ids double as priority levels: a larger id wins.
  localparam logic [1:0] ID_NONE   = 2'd0;
  localparam logic [1:0] ID_WALL   = 2'd1;
  localparam logic [1:0] ID_PADDLE = 2'd2;
  localparam logic [1:0] ID_SCORE  = 2'd3;

  state_t      state, state_nxt;
  logic [1:0]  id_q, id_nxt;
  logic [15:0] cnt_q, cnt_nxt;
  logic        snd_q, snd_nxt;
  logic [5:0]  frames_q, frames_nxt;

  logic [1:0]  req_id;
  logic [15:0] half_cur;
  logic        tone_wrap;
  logic        do_load;
  logic [1:0]  load_id;

`ifdef SOUND_ARB_QUEUE_EN
  // Pending flags, bit 0 = wall, bit 1 = paddle, bit 2 = score.
  logic [2:0]  pend_q, pend_nxt;
  logic [2:0]  req_vec;
  logic [1:0]  pend_hi;
  logic [1:0]  top_id;
`endif

  function automatic logic [15:0] half_of(input logic [1:0] id);
    case (id)
      ID_WALL:   half_of = HALF_WALL;
      ID_PADDLE: half_of = HALF_PADDLE;
      ID_SCORE:  half_of = HALF_SCORE;
      default:   half_of = 16'd0;
    endcase
  endfunction

  function automatic logic [5:0] dur_of(input logic [1:0] id);
    case (id)
      ID_WALL:   dur_of = DUR_WALL;
      ID_PADDLE: dur_of = DUR_PADDLE;
      ID_SCORE:  dur_of = DUR_SCORE;
      default:   dur_of = 6'd0;
    endcase
  endfunction

`ifdef SOUND_ARB_QUEUE_EN
  // One-hot flag position of a source id.
  function automatic logic [2:0] id_mask(input logic [1:0] id);
    case (id)
      ID_WALL:   id_mask = 3'b001;
      ID_PADDLE: id_mask = 3'b010;
      ID_SCORE:  id_mask = 3'b100;
      default:   id_mask = 3'b000;
    endcase
  endfunction

  // Flags of all sources strictly below the given priority.
  function automatic logic [2:0] below_mask(input logic [1:0] id);
    case (id)
      ID_PADDLE: below_mask = 3'b001;
      ID_SCORE:  below_mask = 3'b011;
      default:   below_mask = 3'b000;
    endcase
  endfunction
`endif

  // Highest-priority request this cycle, and the wrap point of the current tone.
  always_comb begin
    if (req_score)       req_id = ID_SCORE;
    else if (req_paddle) req_id = ID_PADDLE;
    else if (req_wall)   req_id = ID_WALL;
    else                 req_id = ID_NONE;
    half_cur  = half_of(id_q);
    // Half-periods of 0 or 1 both mean "toggle every cycle".
    tone_wrap = (half_cur <= 16'd1) || (cnt_q == half_cur - 16'd1);
`ifdef SOUND_ARB_QUEUE_EN
    req_vec = {req_score, req_paddle, req_wall};
    if (pend_q[2])      pend_hi = ID_SCORE;
    else if (pend_q[1]) pend_hi = ID_PADDLE;
    else if (pend_q[0]) pend_hi = ID_WALL;
    else                pend_hi = ID_NONE;
    top_id = (req_id > id_q) ? req_id : id_q;
`endif
  end

  // Next-state and next-register logic; with en low everything holds.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_nxt  = state;
    id_nxt     = id_q;
    cnt_nxt    = cnt_q;
    snd_nxt    = snd_q;
    frames_nxt = frames_q;
    do_load    = 1'b0;
    load_id    = ID_NONE;
`ifdef SOUND_ARB_QUEUE_EN
    pend_nxt   = pend_q;
`endif
    if (en) begin
      case (state)
        IDLE: begin
          load_id = req_id;
`ifdef SOUND_ARB_QUEUE_EN
          if (pend_hi > load_id) load_id = pend_hi;
          pend_nxt = pend_q & ~id_mask(load_id);
`endif
          do_load = (load_id != ID_NONE);
        end
        PLAY: begin
          if (tone_wrap) begin
            cnt_nxt = 16'd0;
            snd_nxt = ~snd_q;
          end else begin
            cnt_nxt = cnt_q + 16'd1;
          end
          if (req_id > id_q) begin
            // Preemption: restart with the new tone; any tick is ignored.
            do_load = 1'b1;
            load_id = req_id;
          end else if (req_id == id_q) begin
            // Same source again: extend only, tone phase keeps running.
            frames_nxt = dur_of(id_q);
          end else if (frame_tick) begin
            if (frames_q <= 6'd1) begin
              state_nxt  = IDLE;
              id_nxt     = ID_NONE;
              cnt_nxt    = 16'd0;
              snd_nxt    = 1'b0;
              frames_nxt = 6'd0;
            end else begin
              frames_nxt = frames_q - 6'd1;
            end
          end
`ifdef SOUND_ARB_QUEUE_EN
          pend_nxt = pend_q | (req_vec & below_mask(top_id));
`endif
        end
        default: state_nxt = IDLE;
      endcase
      if (do_load) begin
        state_nxt  = PLAY;
        id_nxt     = load_id;
        cnt_nxt    = 16'd0;
        snd_nxt    = 1'b0;
        frames_nxt = dur_of(load_id);
      end
    end
  end

  // State registers with synchronous reset that overrides en.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state    <= IDLE;
      id_q     <= ID_NONE;
      cnt_q    <= 16'd0;
      snd_q    <= 1'b0;
      frames_q <= 6'd0;
`ifdef SOUND_ARB_QUEUE_EN
      pend_q   <= 3'b000;
`endif
    end else begin
      state    <= state_nxt;
      id_q     <= id_nxt;
      cnt_q    <= cnt_nxt;
      snd_q    <= snd_nxt;
      frames_q <= frames_nxt;
`ifdef SOUND_ARB_QUEUE_EN
      pend_q   <= pend_nxt;
`endif
    end
  end

  // Audio is muted while disabled without disturbing the stored phase.
  assign sound_out = snd_q & en;
  assign busy      = (state == PLAY);
  assign active_id = id_q;

endmodule

// File: tb/tb_pong_sound_arbiter.sv
// Self-checking bench for pong_sound_arbiter. A behavioural model tracks the
// tone as "elapsed enabled cycles since grant" and derives the square wave by
// division; a compare process checks all outputs every cycle, and the directed
// sequence adds literal expectations at the interesting points.
module tb_pong_sound_arbiter;

  localparam int HW = 4, HP = 1, HS = 5;
  localparam int DW = 2, DP = 3, DS = 4;

  logic       clk = 1'b0;
  logic       rst, en, frame_tick, req_wall, req_paddle, req_score;
  logic       sound_out, busy;
  logic [1:0] active_id;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_on  = 1'b0;

  pong_sound_arbiter #(
    .HALF_WALL(16'd4), .HALF_PADDLE(16'd1), .HALF_SCORE(16'd5),
    .DUR_WALL(6'd2), .DUR_PADDLE(6'd3), .DUR_SCORE(6'd4)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .frame_tick(frame_tick),
    .req_wall(req_wall), .req_paddle(req_paddle), .req_score(req_score),
    .sound_out(sound_out), .busy(busy), .active_id(active_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_total++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
  endtask

  // ---------------- behavioural model ----------------
  bit m_busy = 0;
  int m_id = 0, m_el = 0, m_fr = 0;
  bit [3:1] m_pend = '0;

  function automatic int dur(input int id);
    return (id == 3) ? DS : (id == 2) ? DP : (id == 1) ? DW : 0;
  endfunction

  function automatic int half(input int id);
    int h;
    h = (id == 3) ? HS : (id == 2) ? HP : HW;
    return (h < 1) ? 1 : h;
  endfunction

  function automatic bit reqd(input int s);
    return (s == 3) ? req_score : (s == 2) ? req_paddle : req_wall;
  endfunction

  always @(posedge clk) begin
    int r, g, top;
    if (rst) begin
      m_busy = 0; m_id = 0; m_el = 0; m_fr = 0; m_pend = '0;
    end else if (en) begin
      r = req_score ? 3 : req_paddle ? 2 : req_wall ? 1 : 0;
      if (!m_busy) begin
        g = r;
`ifdef SOUND_ARB_QUEUE_EN
        for (int s = 1; s <= 3; s++) if (m_pend[s] && s > g) g = s;
`endif
        if (g != 0) begin
          m_busy = 1; m_id = g; m_el = 0; m_fr = dur(g); m_pend[g] = 0;
        end
      end else begin
        top = (r > m_id) ? r : m_id;
`ifdef SOUND_ARB_QUEUE_EN
        for (int s = 1; s <= 3; s++) if (reqd(s) && s < top) m_pend[s] = 1;
`endif
        m_el++;
        if (r > m_id) begin
          m_id = r; m_el = 0; m_fr = dur(r);
        end else if (r == m_id) begin
          m_fr = dur(m_id);
        end else if (frame_tick) begin
          if (m_fr == 1) begin
            m_busy = 0; m_id = 0; m_el = 0; m_fr = 0;
          end else m_fr--;
        end
      end
    end
  end

  // Every-cycle comparison against the model, settled after the edge.
  always @(posedge clk) begin
    int exp_snd;
    #2;
    if (chk_on) begin
      exp_snd = (m_busy && en) ? ((m_el / half(m_id)) % 2) : 0;
      check("model_busy", int'(busy), int'(m_busy));
      check("model_active_id", int'(active_id), m_id);
      check("model_sound_out", int'(sound_out), exp_snd);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input bit w, input bit p, input bit s, input bit t,
                     input bit e, input bit r);
    @(negedge clk);
    req_wall = w; req_paddle = p; req_score = s; frame_tick = t; en = e; rst = r;
    @(posedge clk);
    #3;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 1, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 1, 1, 0);
  endtask

  initial begin
    rst = 1; en = 0; frame_tick = 0; req_wall = 0; req_paddle = 0; req_score = 0;
    cyc(0, 0, 0, 0, 1, 1);
    cyc(1, 1, 1, 1, 1, 1);
    check("reset_busy", busy, 0);
    check("reset_id", active_id, 0);
    check("reset_sound", sound_out, 0);
    chk_on = 1;

    // Single wall tone, half-period 4, two frames.
    cyc(1, 0, 0, 0, 1, 0);
    check("wall_busy", busy, 1);
    check("wall_id", active_id, 1);
    check("wall_sound_start", sound_out, 0);
    idle(3);
    check("wall_sound_before_toggle", sound_out, 0);
    idle(1);
    check("wall_first_toggle", sound_out, 1);
    idle(4);
    check("wall_second_toggle", sound_out, 0);
    ticks(1);
    check("wall_after_tick1", busy, 1);
    ticks(1);
    check("wall_idle_after_tick2", busy, 0);
    check("wall_idle_id", active_id, 0);

    // Simultaneous wall and score: score wins, four frames.
    cyc(1, 0, 1, 0, 1, 0);
    check("simul_id", active_id, 3);
    ticks(3);
    check("simul_still_busy", busy, 1);
    ticks(1);
    check("simul_done", busy, 0);
    idle(1);

    // Score preempts a playing wall tone ten cycles in.
    cyc(1, 0, 0, 0, 1, 0);
    idle(9);
    cyc(0, 0, 1, 0, 1, 0);
    check("preempt_id", active_id, 3);
    check("preempt_sound", sound_out, 0);
    ticks(4);
    idle(1);

    // Lower-priority paddle during score.
    cyc(0, 0, 1, 0, 1, 0);
    idle(2);
    cyc(0, 1, 0, 0, 1, 0);
    check("lower_keeps_id", active_id, 3);
    ticks(4);
    check("lower_score_end", busy, 0);
    idle(1);
`ifdef SOUND_ARB_QUEUE_EN
    check("queued_paddle_id", active_id, 2);
`else
    check("dropped_paddle_id", active_id, 0);
`endif
    ticks(3);
    idle(2);

    // Same-source request extends the duration.
    cyc(1, 0, 0, 0, 1, 0);
    ticks(1);
    cyc(1, 0, 0, 0, 1, 0);
    ticks(1);
    check("restart_extends", busy, 1);
    ticks(1);
    check("restart_ends", busy, 0);

    // Paddle half-period 1 toggles every cycle.
    cyc(0, 1, 0, 0, 1, 0);
    check("fast_start", sound_out, 0);
    idle(1);
    check("fast_toggle1", sound_out, 1);
    idle(1);
    check("fast_toggle2", sound_out, 0);
    ticks(3);
    idle(1);

    // Freeze with en low for 100 cycles, with ticks and requests.
    cyc(1, 0, 0, 0, 1, 0);
    idle(5);
    for (int i = 0; i < 100; i++)
      cyc(i % 5 == 0, i % 7 == 0, i % 11 == 0, i % 3 == 0, 0, 0);
    check("freeze_sound", sound_out, 0);
    check("freeze_busy", busy, 1);
    check("freeze_id", active_id, 1);
    idle(1);
    check("resume_phase", sound_out, 1);
    ticks(2);
    idle(1);

    // Reset mid-tone with a simultaneous score request.
    cyc(1, 0, 0, 0, 1, 0);
    idle(5);
    cyc(0, 0, 1, 0, 1, 1);
    check("rst_busy", busy, 0);
    check("rst_id", active_id, 0);
    check("rst_sound", sound_out, 0);
    idle(1);
    check("rst_req_dropped", busy, 0);
    idle(2);

    chk_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
